// File: rtl/ahblsram_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the AHB-Lite LSRAM slave front end: FSM state codes, HTRANS,
// HRESP and HSIZE values.
package ahblsram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR1 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PEND = ST_PEND,
    S_WAIT = ST_WAIT,
    S_ERR1 = ST_ERR1
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahblsram_ahb_slave_if.sv
`timescale 1ns/1ps
// AHB-Lite slave front end for the LSRAM store: captures address phases, issues one-cycle
// requests to the SRAM controller and stretches the data phase until its ack.
// Define AHB_SRAM_ERR_RESP_EN to return a two-cycle ERROR for out-of-range or oversize accesses.
//
//  state  | meaning
//  S_IDLE | ready; accept a new address phase (also the second ERROR cycle)
//  S_PEND | captured transfer waiting for BUSY low; req issued from here
//  S_WAIT | req issued, waiting for sramahb_ack
//  S_ERR1 | first ERROR cycle, HREADYOUT low
module ahblsram_ahb_slave_if
  import ahblsram_pkg::*;
#(
  parameter int AHB_DWIDTH = 32,
  parameter int AHB_AWIDTH = 20,
  parameter int MEM_BYTES  = 2048
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [AHB_AWIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADYIN,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [AHB_AWIDTH-1:0] ahbsram_addr,
  output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
  input  logic                  sramahb_ack,
  input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
  input  logic                  BUSY
);

  if (AHB_DWIDTH != 32) begin : g_dwidth_check
    $error("ahblsram_ahb_slave_if supports AHB_DWIDTH=32 only");
  end
  if ((MEM_BYTES % 4 != 0) || (MEM_BYTES > (1 << AHB_AWIDTH))) begin : g_mem_check
    $error("ahblsram_ahb_slave_if: MEM_BYTES must be word aligned and addressable");
  end

  state_t                state;
  logic [AHB_DWIDTH-1:0] rdata_q;
  logic                  capture;
  logic                  bad_xfer;
  logic                  ack_rd;

  assign capture = HSEL & HREADYIN & HREADYOUT &
                   ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

`ifdef AHB_SRAM_ERR_RESP_EN
  localparam logic [AHB_AWIDTH-1:0] MEM_LIMIT = AHB_AWIDTH'(MEM_BYTES);
  logic err_resp;

  assign bad_xfer = (HADDR >= MEM_LIMIT) | (HSIZE > HSIZE_WORD);

  // ERROR is held through ERR1 and the following ready cycle, which is the second ERROR cycle
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) err_resp <= 1'b0;
    else          err_resp <= (capture & bad_xfer) | (state == S_ERR1);
  end

  assign HRESP = err_resp ? HRESP_ERROR : HRESP_OKAY;
`else
  assign bad_xfer = 1'b0;
  assign HRESP    = HRESP_OKAY;
`endif

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state         <= S_IDLE;
      rdata_q       <= '0;
      ahbsram_addr  <= '0;
      ahbsram_size  <= '0;
      ahbsram_write <= 1'b0;
    end else begin
      if (capture) begin
        ahbsram_addr  <= HADDR;
        ahbsram_size  <= HSIZE;
        ahbsram_write <= HWRITE;
      end
      if (ack_rd) rdata_q <= sramahb_rdata;
      case (state)
        S_IDLE:  if (capture) state <= bad_xfer ? S_ERR1 : S_PEND;
        S_PEND:  if (!BUSY) state <= S_WAIT;
        S_WAIT:  if (sramahb_ack) state <= capture ? (bad_xfer ? S_ERR1 : S_PEND) : S_IDLE;
        S_ERR1:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    case (state)
      S_PEND, S_ERR1: HREADYOUT = 1'b0;
      S_WAIT:         HREADYOUT = sramahb_ack;
      default:        HREADYOUT = 1'b1;
    endcase
  end

  // Read data is forwarded in the ack cycle itself and then held; write acks leave it alone
  assign ack_rd        = (state == S_WAIT) & sramahb_ack & ~ahbsram_write;
  assign HRDATA        = ack_rd ? sramahb_rdata : rdata_q;
  assign ahbsram_req   = (state == S_PEND) & ~BUSY;
  assign ahbsram_wdata = HWDATA;

endmodule
